// File: rtl/fi_campaign_ctrl_if.sv
// rtl/fi_campaign_ctrl_if.sv - campaign descriptor handshake interface for fi_campaign_ctrl
interface fi_campaign_ctrl_if #(
  parameter int address_width = 8,
  parameter int counter_width = 32
);
  logic                     cfg_valid;
  logic                     cfg_ready;
  logic [address_width-1:0] cfg_addr;
  logic [address_width-1:0] cfg_stride;
  logic [counter_width-1:0] cfg_delay;
  logic [counter_width-1:0] cfg_pulse;
  logic [counter_width-1:0] cfg_count;

  // Sequencer / CSR side: presents descriptors
  modport master (
    output cfg_valid, cfg_addr, cfg_stride, cfg_delay, cfg_pulse, cfg_count,
    input  cfg_ready
  );

  // Controller side: accepts descriptors
  modport slave (
    input  cfg_valid, cfg_addr, cfg_stride, cfg_delay, cfg_pulse, cfg_count,
    output cfg_ready
  );
endinterface

// File: rtl/fi_campaign_ctrl.sv
// rtl/fi_campaign_ctrl.sv - fault-injection campaign sequencer driving a one-hot fault vector (optional FI_JITTER_EN delay jitter)
module fi_campaign_ctrl #(
  parameter int N             = 256,
  parameter int address_width = 8,
  parameter int counter_width = 32
) (
  input  logic            clk,
  input  logic            rstn,
  fi_campaign_ctrl_if.slave cfg,
  input  logic            abort,
  output logic            busy,
  output logic            done,
  output logic            aborted,
  output logic [N-1:0]    fi_out
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_FIRE = 2'd2;
  localparam logic [1:0] S_FIN  = 2'd3;

  // Shifting past the top bit naturally yields zero, so out-of-range targets fire nothing
  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  logic [1:0]               state_q, state_d;
  logic [address_width-1:0] addr_q, addr_d;
  logic [address_width-1:0] stride_q, stride_d;
  logic [counter_width-1:0] delay_q, delay_d;
  logic [counter_width-1:0] pulse_q, pulse_d;
  logic [counter_width-1:0] remaining_q, remaining_d;
  logic [counter_width-1:0] dcnt_q, dcnt_d;
  logic [counter_width-1:0] pcnt_q, pcnt_d;
  logic [N-1:0]             fi_out_q, fi_out_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     aborted_q, aborted_d;
  logic                     ready_q, ready_d;

  logic                     accept;
  logic [counter_width-1:0] wait_delay;
  logic [counter_width-1:0] dload;
  logic [counter_width-1:0] pload;
  logic                     shot_load;

  assign accept     = cfg.cfg_valid & ready_q;
  // At accept the descriptor is still on the bus; later shots use the captured copy
  assign wait_delay = (state_q == S_IDLE) ? cfg.cfg_delay : delay_q;
  assign pload      = (pulse_q == '0) ? '0 : pulse_q - 1'b1;

`ifdef FI_JITTER_EN
  logic [15:0]              lfsr_q, lfsr_d;
  logic [counter_width:0]   dsum;

  // Delay plus LFSR jitter, saturating at the counter ceiling
  always_comb begin
    dsum   = {1'b0, wait_delay} + {{(counter_width-3){1'b0}}, lfsr_q[3:0]};
    dload  = dsum[counter_width] ? '1 : dsum[counter_width-1:0];
    lfsr_d = lfsr_q;
    if (shot_load) lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  // LFSR state, advances once per WAIT load
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) lfsr_q <= 16'hACE1;
    else       lfsr_q <= lfsr_d;
  end
`else
  assign dload = wait_delay;
`endif

  // Next-state logic for the campaign FSM and its counters
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    stride_d    = stride_q;
    delay_d     = delay_q;
    pulse_d     = pulse_q;
    remaining_d = remaining_q;
    dcnt_d      = dcnt_q;
    pcnt_d      = pcnt_q;
    fi_out_d    = '0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    aborted_d   = aborted_q;
    ready_d     = ready_q;
    shot_load   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          addr_d      = cfg.cfg_addr;
          stride_d    = cfg.cfg_stride;
          delay_d     = cfg.cfg_delay;
          pulse_d     = cfg.cfg_pulse;
          remaining_d = cfg.cfg_count;
          aborted_d   = 1'b0;
          ready_d     = 1'b0;
          if (cfg.cfg_count == '0) begin
            state_d = S_FIN;
            done_d  = 1'b1;
          end else begin
            state_d   = S_WAIT;
            dcnt_d    = dload;
            busy_d    = 1'b1;
            shot_load = 1'b1;
          end
        end
      end

      S_WAIT: begin
        if (abort) begin
          state_d   = S_FIN;
          done_d    = 1'b1;
          aborted_d = 1'b1;
          busy_d    = 1'b0;
        end else if (dcnt_q == '0) begin
          state_d  = S_FIRE;
          pcnt_d   = pload;
          fi_out_d = ONE << addr_q;
        end else begin
          dcnt_d = dcnt_q - 1'b1;
        end
      end

      S_FIRE: begin
        if (abort) begin
          state_d   = S_FIN;
          done_d    = 1'b1;
          aborted_d = 1'b1;
          busy_d    = 1'b0;
        end else if (pcnt_q == '0) begin
          remaining_d = remaining_q - 1'b1;
          addr_d      = addr_q + stride_q;
          if (remaining_q == {{(counter_width-1){1'b0}}, 1'b1}) begin
            state_d = S_FIN;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d   = S_WAIT;
            dcnt_d    = dload;
            shot_load = 1'b1;
          end
        end else begin
          pcnt_d   = pcnt_q - 1'b1;
          fi_out_d = ONE << addr_q;
        end
      end

      default: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  // State and output registers; reset clears the fault lines immediately
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      stride_q    <= '0;
      delay_q     <= '0;
      pulse_q     <= '0;
      remaining_q <= '0;
      dcnt_q      <= '0;
      pcnt_q      <= '0;
      fi_out_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      stride_q    <= stride_d;
      delay_q     <= delay_d;
      pulse_q     <= pulse_d;
      remaining_q <= remaining_d;
      dcnt_q      <= dcnt_d;
      pcnt_q      <= pcnt_d;
      fi_out_q    <= fi_out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
      ready_q     <= ready_d;
    end
  end

  assign cfg.cfg_ready = ready_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign aborted       = aborted_q;
  assign fi_out        = fi_out_q;

endmodule

// File: tb/tb_fi_campaign_ctrl.sv
// tb/tb_fi_campaign_ctrl.sv - randomized self-checking bench for fi_campaign_ctrl
module tb_fi_campaign_ctrl;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  fi_campaign_ctrl_if #(.address_width(8), .counter_width(32)) cif ();
  fi_campaign_ctrl_if #(.address_width(8), .counter_width(32)) cif_s ();

  logic         abort;
  logic         busy, done, aborted;
  logic [255:0] fi_out;
  logic         busy_s, done_s, aborted_s;
  logic [199:0] fi_out_s;

  fi_campaign_ctrl #(.N(256), .address_width(8), .counter_width(32)) dut (
    .clk(clk), .rstn(rstn), .cfg(cif), .abort(abort),
    .busy(busy), .done(done), .aborted(aborted), .fi_out(fi_out)
  );

  fi_campaign_ctrl #(.N(200), .address_width(8), .counter_width(32)) dut_s (
    .clk(clk), .rstn(rstn), .cfg(cif_s), .abort(abort),
    .busy(busy_s), .done(done_s), .aborted(aborted_s), .fi_out(fi_out_s)
  );

  int checks = 0;
  int errors = 0;
  bit exp_aborted = 1'b0;

  typedef struct {
    int unsigned addr;
    int unsigned stride;
    int unsigned delay;
    int unsigned pulse;
    int unsigned count;
  } desc_t;

  function automatic desc_t mk(int unsigned a, int unsigned s, int unsigned dl, int unsigned p, int unsigned c);
    desc_t d;
    d.addr = a; d.stride = s; d.delay = dl; d.pulse = p; d.count = c;
    return d;
  endfunction

  function automatic int nat_end(desc_t d);
    int pe;
    pe = (d.pulse == 0) ? 1 : int'(d.pulse);
    return int'(d.count) * (int'(d.delay) + 1 + pe);
  endfunction

  task automatic drive(input bit v, input desc_t d);
    cif.cfg_valid    = v;         cif_s.cfg_valid    = v;
    cif.cfg_addr     = 8'(d.addr);   cif_s.cfg_addr   = 8'(d.addr);
    cif.cfg_stride   = 8'(d.stride); cif_s.cfg_stride = 8'(d.stride);
    cif.cfg_delay    = d.delay;   cif_s.cfg_delay    = d.delay;
    cif.cfg_pulse    = d.pulse;   cif_s.cfg_pulse    = d.pulse;
    cif.cfg_count    = d.count;   cif_s.cfg_count    = d.count;
  endtask

  task automatic begin_cfg(input string name, input desc_t d);
    checks++;
    if (cif.cfg_ready !== 1'b1 || cif_s.cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_before_accept got %b/%b exp 1", name, cif.cfg_ready, cif_s.cfg_ready);
    end
    drive(1'b1, d);
  endtask

  // Called at the negedge where the descriptor is presented; the next edge accepts it
  task automatic check_campaign(input string name, input desc_t d, input int abort_e,
                                input bit keep_valid, input desc_t nd);
    int per, pe, nat, end_e, k, r, a;
    bit ab, fire;
    logic [255:0] ef;
    logic [199:0] efs;
    pe    = (d.pulse == 0) ? 1 : int'(d.pulse);
    per   = int'(d.delay) + 1 + pe;
    nat   = nat_end(d);
    ab    = (abort_e >= 0) && (abort_e < nat);
    end_e = ab ? abort_e + 1 : nat;
    @(negedge clk);
    if (keep_valid) drive(1'b1, nd);
    else drive(1'b0, mk($urandom_range(0, 255), $urandom_range(0, 255), $urandom, $urandom, $urandom));
    for (int e = 0; e <= end_e + 1; e++) begin
      if (e > 0) @(negedge clk);
      ef = '0; efs = '0;
      fire = (e < end_e) && (e >= int'(d.delay) + 1) && (((e - int'(d.delay) - 1) % per) < pe);
      if (fire) begin
        k = (e - int'(d.delay) - 1) / per;
        r = int'(d.addr) + k * int'(d.stride);
        a = r % 256;
        ef[a] = 1'b1;
        if (a < 200) efs[a] = 1'b1;
      end
      checks++;
      if (fi_out !== ef) begin
        errors++;
        $display("FAIL %s fi_out e=%0d got %h exp %h", name, e, fi_out, ef);
      end
      checks++;
      if (fi_out_s !== efs) begin
        errors++;
        $display("FAIL %s fi_out_n200 e=%0d got %h exp %h", name, e, fi_out_s, efs);
      end
      checks++;
      if (busy !== (e < end_e) || busy_s !== (e < end_e)) begin
        errors++;
        $display("FAIL %s busy e=%0d got %b/%b exp %b", name, e, busy, busy_s, e < end_e);
      end
      checks++;
      if (done !== (e == end_e) || done_s !== (e == end_e)) begin
        errors++;
        $display("FAIL %s done e=%0d got %b/%b exp %b", name, e, done, done_s, e == end_e);
      end
      checks++;
      if (aborted !== ((e >= end_e) && ab) || aborted_s !== ((e >= end_e) && ab)) begin
        errors++;
        $display("FAIL %s aborted e=%0d got %b/%b exp %b", name, e, aborted, aborted_s, (e >= end_e) && ab);
      end
      checks++;
      if (cif.cfg_ready !== (e > end_e) || cif_s.cfg_ready !== (e > end_e)) begin
        errors++;
        $display("FAIL %s cfg_ready e=%0d got %b/%b exp %b", name, e, cif.cfg_ready, cif_s.cfg_ready, e > end_e);
      end
      abort = (e == abort_e);
    end
    abort = 1'b0;
    exp_aborted = ab;
  endtask

  task automatic run(input string name, input desc_t d, input int abort_e);
    begin_cfg(name, d);
    check_campaign(name, d, abort_e, 1'b0, d);
  endtask

  task automatic test_reset();
    abort = 1'b0;
    drive(1'b0, mk(0, 0, 0, 0, 0));
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (fi_out !== '0 || fi_out_s !== '0 || busy !== 1'b0 || done !== 1'b0 ||
        aborted !== 1'b0 || cif.cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state got fi=%h busy=%b done=%b ab=%b rdy=%b exp 0/0/0/0/1",
               fi_out, busy, done, aborted, cif.cfg_ready);
    end
  endtask

  task automatic test_single_shot();
    run("single_shot", mk(7, 0, 100, 2, 1), -1);
  endtask

  task automatic test_wrap();
    run("wrap", mk(250, 4, 3, 1, 3), -1);
  endtask

  task automatic test_out_of_range();
    run("out_of_range", mk(210, 0, 2, 3, 1), -1);
  endtask

  task automatic test_boundaries();
    run("count0", mk(9, 1, 5, 5, 0), -1);
    run("pulse0", mk(3, 1, 2, 0, 2), -1);
    run("delay0", mk(100, 17, 0, 2, 3), -1);
    run("delay0_pulse0", mk(255, 1, 0, 0, 4), -1);
  endtask

  task automatic test_back_to_back();
    desc_t a, b;
    a = mk(12, 3, 2, 2, 2);
    b = mk(40, 250, 1, 3, 2);
    begin_cfg("b2b_first", a);
    check_campaign("b2b_first", a, -1, 1'b1, b);
    begin_cfg("b2b_second", b);
    check_campaign("b2b_second", b, -1, 1'b0, b);
  endtask

  task automatic test_abort();
    run("abort_wait", mk(20, 1, 5, 2, 4), 10);
    run("abort_last_edge", mk(30, 2, 1, 2, 2), 7);
  endtask

  task automatic test_abort_idle();
    abort = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (aborted !== exp_aborted || busy !== 1'b0 || done !== 1'b0 || cif.cfg_ready !== 1'b1) begin
        errors++;
        $display("FAIL abort_idle got ab=%b busy=%b done=%b rdy=%b exp %b/0/0/1",
                 aborted, busy, done, cif.cfg_ready, exp_aborted);
      end
    end
    abort = 1'b0;
    run("after_abort", mk(60, 5, 1, 1, 2), -1);
  endtask

  task automatic test_random();
    desc_t d;
    int ae;
    for (int i = 0; i < 12; i++) begin
      d = mk($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 6),
             $urandom_range(0, 4), $urandom_range(0, 5));
      ae = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, nat_end(d))) : -1;
      run("random", d, ae);
    end
  endtask

  task automatic test_reset_mid_fire();
    desc_t d;
    d = mk(5, 0, 2, 10, 1);
    begin_cfg("reset_mid_fire", d);
    @(negedge clk);
    drive(1'b0, d);
    for (int e = 1; e <= 5; e++) @(negedge clk);
    checks++;
    if (fi_out[5] !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_fire pre_reset_bit5 got %b exp 1", fi_out[5]);
    end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if (fi_out !== '0 || fi_out_s !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_fire async_clear got fi=%h busy=%b exp 0/0", fi_out, busy);
    end
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || cif.cfg_ready !== 1'b1 || fi_out !== '0) begin
      errors++;
      $display("FAIL reset_mid_fire release got busy=%b done=%b rdy=%b exp 0/0/1",
               busy, done, cif.cfg_ready);
    end
    exp_aborted = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_shot();
    test_wrap();
    test_out_of_range();
    test_boundaries();
    test_back_to_back();
    test_abort();
    test_abort_idle();
    test_random();
    test_reset_mid_fire();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fi_campaign_ctrl.md
Name: fi_campaign_ctrl

Overview:
- Sequences a fault-injection campaign onto the N-bit one-hot fault vector.
- Accepts one campaign descriptor over a valid/ready handshake. The descriptor holds start address, delay, pulse length, shot count and address stride.
- Fires the programmed number of pulses, each preceded by the delay, and advances the target bit by the stride after every shot.
- Sits between the test sequencer/CSR layer and the fault lines of the design under attack; it replaces fixed-parameter injection with run-time control.

Parameters:
- N, 256: width of fi_out, i.e. number of fault lines.
- address_width, 8: width of address and stride; must satisfy 2^address_width >= N.
- counter_width, 32: width of the delay, pulse and count fields.

Ports:
- clk  in  1  single clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- cfg_valid  in  1  descriptor valid.
- cfg_ready  out  1  descriptor accepted when cfg_valid & cfg_ready at the same edge.
- cfg_addr  in  address_width  first target bit.
- cfg_stride  in  address_width  address increment per shot.
- cfg_delay  in  counter_width  idle cycles before each pulse.
- cfg_pulse  in  counter_width  pulse length in cycles.
- cfg_count  in  counter_width  number of shots.
- abort  in  1  cancel the campaign.
- busy  out  1  campaign in progress.
- done  out  1  one-cycle completion pulse.
- aborted  out  1  qualifies done: campaign ended by abort.
- fi_out  out  N  one-hot fault vector.

Behaviour:
- Reset (asynchronous, rstn=0): state=IDLE; fi_out=0, busy=0, done=0, aborted=0, cfg_ready=1. All internal counters and the address register are 0.
- All outputs are registered. cfg_ready=1 only in IDLE. Descriptor fields are sampled only at the accept edge; later input changes have no effect.
- States: IDLE, WAIT, FIRE, FIN.
- IDLE: on accept with cfg_count=0, go to FIN (no pulse). Otherwise go to WAIT with addr=cfg_addr, remaining=cfg_count, dcnt=cfg_delay. busy=1 from the next cycle.
- WAIT: if dcnt==0, go to FIRE and load pcnt=max(cfg_pulse,1)-1; otherwise decrement dcnt.
- FIRE: fi_out = (1<<addr) while in FIRE. If addr>=N, fi_out=0 for that shot but the shot still counts.
  - When pcnt==0, decrement remaining and set addr = addr+cfg_stride mod 2^address_width (wraps).
  - If remaining becomes 0, go to FIN; otherwise go to WAIT with dcnt=cfg_delay.
  - fi_out is 0 in the cycle after the last FIRE cycle.
- Timing: accept at edge t0. fi_out is high from edge t0+D+1 through edge t0+D+1+P. Period between shots = D+1+P cycles (P treated as 1 when 0).
- FIN: done=1 for exactly one cycle, busy=0; return to IDLE with cfg_ready=1 on the following edge.
- abort: sampled in WAIT or FIRE. At the next edge fi_out=0 and state goes to FIN with aborted=1. aborted holds until the next accept.
  - abort in IDLE or FIN is ignored.
  - abort in the same cycle as pcnt==0 on the last shot: abort wins, aborted=1.
- Counters never underflow. Count ranges span the full counter_width.
- Reset mid-campaign clears fi_out immediately (asynchronously); no done pulse is generated.

Optional Feature:
- Macro FI_JITTER_EN.
- Defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 at reset) advances once per shot at the WAIT load. The effective delay is cfg_delay + lfsr[3:0], saturating at 2^counter_width-1.
- Undefined: the LFSR is absent and the delay is exactly cfg_delay; timing is as stated above.

Test Plan:
- Reset mid-FIRE (addr=5, P=10, rstn low at pulse cycle 3) -> fi_out=0 immediately; busy=0, done=0, cfg_ready=1 after release.
- Single shot: addr=7, D=100, P=2, count=1 -> fi_out[7] high exactly 2 cycles starting 101 cycles after accept; done pulses 1 cycle; no other bit ever set.
- Multi-shot with wrap: addr=250, stride=4, D=3, P=1, count=3 -> pulses on bits 250, 254, then addr=2 (wrap of 8-bit sum 258); period 5 cycles; done once.
- Out of range: N=200, addr=210, count=1 -> fi_out stays 0 throughout; done=1, aborted=0.
- Boundaries: count=0 -> done 1 cycle after accept, no pulse. P=0 -> 1-cycle pulse. D=0 -> pulse 1 cycle after accept. cfg_valid held during busy -> not accepted until cfg_ready returns.
- Abort during WAIT of the second shot (count=4) -> fi_out stays 0, done=1 with aborted=1, exactly one pulse observed; the next campaign clears aborted on accept.
